// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Accepts a byte stream, assembles big-endian 32-bit
//               instruction words and writes them to a writable instruction
//               memory port. Holds the processor (CpuHold) while loading.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : one trailing checksum byte (XOR of all data bytes) is accepted
//               after the last word. ChkErr flags a mismatch and holds until
//               the next accepted Start.
//   undefined : no checksum stage, ChkErr is constant 0.
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_WIDTH  word-address width of the target memory (default 9 = 512 words)
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   Start      in   one-cycle pulse, begins a load (ignored while Busy)
//   WordCount  in   number of words to load, sampled on accepted Start
//   ByteIn     in   incoming byte
//   ByteValid  in   ByteIn valid
//   ByteReady  out  loader accepts a byte this cycle
//   WrEn       out  one-cycle memory write strobe
//   WrAddress  out  byte address of the write (bits [1:0] = 0)
//   WrData     out  assembled instruction word
//   Busy       out  load in progress
//   Done       out  one-cycle pulse, load finished
//   CpuHold    out  processor hold, equal to Busy
//   ChkErr     out  checksum mismatch flag
// ============================================================================
module instruction_loader #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH:0]   WordCount,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  WrEn,
    output logic [31:0]           WrAddress,
    output logic [31:0]           WrData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  CpuHold,
    output logic                  ChkErr
);

    // Largest legal word count: the full memory depth.
    localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state;
    logic [ADDR_WIDTH:0] word_total;   // clamped word count of this load
    logic [ADDR_WIDTH:0] word_addr;    // word index of the next write
    logic [1:0]          byte_idx;     // bytes already received for this word
    logic [23:0]         shift_reg;    // first three bytes of the current word

    logic                xfer;
    logic [ADDR_WIDTH:0] next_addr;
    logic [31:0]         addr_bytes;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          run_xor;      // XOR of all data bytes of this load
`endif

    assign xfer       = ByteValid & ByteReady;
    assign next_addr  = word_addr + ONE_WORD;
    // The clamp keeps word_addr below MAX_COUNT while a write is issued, so
    // its top bit is never needed in the byte address.
    assign addr_bytes = {{(30 - ADDR_WIDTH){1'b0}}, word_addr[ADDR_WIDTH-1:0], 2'b00};
    assign CpuHold    = Busy;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            word_total <= '0;
            word_addr  <= '0;
            byte_idx   <= '0;
            shift_reg  <= '0;
            ByteReady  <= 1'b0;
            WrEn       <= 1'b0;
            WrAddress  <= '0;
            WrData     <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            run_xor    <= '0;
            ChkErr     <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            WrEn <= 1'b0;
            Done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (Start) begin
                        Busy      <= 1'b1;
                        word_addr <= '0;
                        byte_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
                        run_xor   <= '0;
                        ChkErr    <= 1'b0;
`endif
                        if (WordCount == '0) begin
                            Done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            word_total <= (WordCount > MAX_COUNT) ? MAX_COUNT : WordCount;
                            ByteReady  <= 1'b1;
                            state      <= S_RECV;
                        end
                    end
                end

                S_RECV: begin
                    if (xfer) begin
                        shift_reg <= {shift_reg[15:0], ByteIn};
                        byte_idx  <= byte_idx + 2'd1;  // wraps to 0 after the 4th byte
`ifdef LOADER_CHECKSUM_EN
                        run_xor   <= run_xor ^ ByteIn;
`endif
                        if (byte_idx == 2'd3) begin
                            // Stall the stream for the write cycle.
                            ByteReady <= 1'b0;
                            WrEn      <= 1'b1;
                            WrAddress <= addr_bytes;
                            WrData    <= {shift_reg, ByteIn};
                            state     <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    word_addr <= next_addr;
                    if (next_addr == word_total) begin
`ifdef LOADER_CHECKSUM_EN
                        ByteReady <= 1'b1;
                        state     <= S_CHECK;
`else
                        Done      <= 1'b1;
                        state     <= S_DONE;
`endif
                    end else begin
                        ByteReady <= 1'b1;
                        state     <= S_RECV;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        ChkErr    <= (ByteIn != run_xor);
                        ByteReady <= 1'b0;
                        Done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    ByteReady <= 1'b0;
                    Busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifndef LOADER_CHECKSUM_EN
    assign ChkErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Self-checking bench for instruction_loader. Table vectors,
//               hand-written timing sequences and randomized loads compared
//               against a word-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

    localparam int AW = 9;
    localparam int MAX_WORDS = 1 << AW;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [AW:0] WordCount = '0;
    logic [7:0]  ByteIn = '0;
    logic        ByteValid = 1'b0;
    logic        ByteReady, WrEn, Busy, Done, CpuHold, ChkErr;
    logic [31:0] WrAddress, WrData;

    int total = 0;
    int bad   = 0;

    logic [7:0]  img_q[$];    // byte image to send
    logic [31:0] exp_q[$];    // expected write data, word k at address 4k
    logic [31:0] wa_q[$];     // observed write addresses
    logic [31:0] wd_q[$];     // observed write data
    int          done_seen = 0;
    logic        mon_en = 1'b0;

    instruction_loader #(.ADDR_WIDTH(AW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .WordCount (WordCount),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .WrEn      (WrEn),
        .WrAddress (WrAddress),
        .WrData    (WrData),
        .Busy      (Busy),
        .Done      (Done),
        .CpuHold   (CpuHold),
        .ChkErr    (ChkErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Passive monitor: records writes, counts Done pulses, checks invariants.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (WrEn) begin
                wa_q.push_back(WrAddress);
                wd_q.push_back(WrData);
                chk("ready_low_in_write", {31'd0, ByteReady}, 32'd0);
            end
            if (Done) done_seen++;
            chk("cpuhold_eq_busy", {31'd0, CpuHold}, {31'd0, Busy});
        end
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent = 1'b0;
        for (int g = 0; g < 500 && !sent; g++) begin
            logic rdy;
            ByteIn    = b;
            ByteValid = ($urandom_range(99) >= gap);
            rdy       = ByteReady;
            @(negedge Clk);
            sent = ByteValid && rdy;
        end
        ByteValid = 1'b0;
        if (!sent) begin
            total++;
            bad++;
            $display("FAIL byte_timeout: got no transfer expected transfer of %h", b);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!Done && n < 20000) begin
            @(negedge Clk);
            n++;
        end
        total++;
        if (!Done) begin
            bad++;
            $display("FAIL %s_done_timeout: got Done=0 expected Done=1", name);
        end
        @(negedge Clk);
    endtask

    task automatic start_load(input logic [AW:0] cnt);
        wa_q.delete();
        wd_q.delete();
        done_seen = 0;
        Start     = 1'b1;
        WordCount = cnt;
        @(negedge Clk);
        Start     = 1'b0;
    endtask

    task automatic run_load(input logic [AW:0] cnt, input int gap, input logic [7:0] chkbyte);
        start_load(cnt);
        foreach (img_q[i]) send_byte(img_q[i], gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(chkbyte, gap);
`else
        if (chkbyte === 8'hxx) $display("unused checksum byte");
`endif
    endtask

    task automatic check_results(input string name, input logic exp_err);
        chk({name, "_nwrites"}, 32'(wa_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < wa_q.size()) begin
                chk({name, "_addr"}, wa_q[i], 32'(4 * i));
                chk({name, "_data"}, wd_q[i], exp_q[i]);
            end
        end
        chk({name, "_done_pulses"}, 32'(done_seen), 32'd1);
        chk({name, "_busy_after"}, {31'd0, Busy}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
        chk({name, "_chkerr"}, {31'd0, ChkErr}, {31'd0, exp_err});
`else
        chk({name, "_chkerr"}, {31'd0, ChkErr}, {31'd0, exp_err & 1'b0});
`endif
    endtask

    // Reference model: words from byte groups (big-endian), clamped count, XOR.
    task automatic model(input int cnt, output logic [7:0] x);
        int n = (cnt > MAX_WORDS) ? MAX_WORDS : cnt;
        exp_q.delete();
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(32'(img_q[4*k])   * 32'h0100_0000 +
                            32'(img_q[4*k+1]) * 32'h0001_0000 +
                            32'(img_q[4*k+2]) * 32'h0000_0100 +
                            32'(img_q[4*k+3]));
            for (int j = 0; j < 4; j++) x = x ^ img_q[4*k+j];
        end
    endtask

    typedef struct packed {
        logic [AW:0]  cnt;
        logic [63:0]  img;      // bytes in send order, first byte in [63:56]
        int           gap;
        logic [7:0]   chkbyte;
        logic [31:0]  e0;
        logic [31:0]  e1;
        logic         err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] x;
        vecs[0] = '{10'd2, 64'h12345678_AABBCCDD, 0,  8'h08, 32'h12345678, 32'hAABBCCDD, 1'b0};
        vecs[1] = '{10'd2, 64'h12345678_AABBCCDD, 45, 8'h09, 32'h12345678, 32'hAABBCCDD, 1'b1};
        vecs[2] = '{10'd1, 64'h01020304_00000000, 0,  8'h04, 32'h01020304, 32'h0,        1'b0};
        vecs[3] = '{10'd1, 64'h01020304_00000000, 20, 8'h05, 32'h01020304, 32'h0,        1'b1};
        vecs[4] = '{10'd1, 64'hDEADBEEF_00000000, 30, 8'h22, 32'hDEADBEEF, 32'h0,        1'b0};

        // ---- reset state ----
        #12;
        chk("rst_ready", {31'd0, ByteReady}, 32'd0);
        chk("rst_wren",  {31'd0, WrEn}, 32'd0);
        chk("rst_busy",  {31'd0, Busy}, 32'd0);
        chk("rst_done",  {31'd0, Done}, 32'd0);
        chk("rst_hold",  {31'd0, CpuHold}, 32'd0);
        chk("rst_addr",  WrAddress, 32'd0);
        chk("rst_data",  WrData, 32'd0);
        @(negedge Clk);
        Reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge Clk);

        // ---- table vectors ----
        foreach (vecs[v]) begin
            img_q.delete();
            exp_q.delete();
            for (int i = 0; i < 4 * int'(vecs[v].cnt); i++) img_q.push_back(vecs[v].img[63-8*i -: 8]);
            exp_q.push_back(vecs[v].e0);
            if (vecs[v].cnt == 10'd2) exp_q.push_back(vecs[v].e1);
            run_load(vecs[v].cnt, vecs[v].gap, vecs[v].chkbyte);
            wait_done("table");
            check_results($sformatf("vec%0d", v), vecs[v].err);
            repeat (2) @(negedge Clk);
        end

        // ---- basic load timing, with a Start pulse while Busy ----
        img_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        start_load(10'd2);
        chk("basic_busy", {31'd0, Busy}, 32'd1);
        foreach (img_q[i]) begin
            if (i == 2) begin
                Start = 1'b1;
                WordCount = 10'd1;
            end
            send_byte(img_q[i], 0);
            Start = 1'b0;
        end
        chk("basic_wren2", {31'd0, WrEn}, 32'd1);
        chk("basic_addr2", WrAddress, 32'h4);
        chk("basic_data2", WrData, 32'hAABBCCDD);
`ifdef LOADER_CHECKSUM_EN
        @(negedge Clk);
        send_byte(8'h08, 0);
`else
        @(negedge Clk);
`endif
        chk("basic_done",     {31'd0, Done}, 32'd1);
        chk("basic_done_bsy", {31'd0, Busy}, 32'd1);
        chk("basic_done_wr",  {31'd0, WrEn}, 32'd0);
        chk("basic_hold_dat", WrData, 32'hAABBCCDD);
        chk("basic_hold_adr", WrAddress, 32'h4);
        @(negedge Clk);
        chk("basic_idle_busy", {31'd0, Busy}, 32'd0);
        chk("basic_idle_done", {31'd0, Done}, 32'd0);
        chk("basic_nwrites", 32'(wa_q.size()), 32'd2);
        @(negedge Clk);

        // ---- zero count; Start during DONE ignored ----
        start_load(10'd0);
        chk("zero_done",  {31'd0, Done}, 32'd1);
        chk("zero_busy",  {31'd0, Busy}, 32'd1);
        chk("zero_ready", {31'd0, ByteReady}, 32'd0);
        Start = 1'b1;
        WordCount = 10'd5;
        @(negedge Clk);
        Start = 1'b0;
        chk("zero_idle_busy", {31'd0, Busy}, 32'd0);
        chk("zero_idle_done", {31'd0, Done}, 32'd0);
        @(negedge Clk);
        chk("zero_ignored_busy", {31'd0, Busy}, 32'd0);
        chk("zero_nwrites", 32'(wa_q.size()), 32'd0);
        chk("zero_chkerr", {31'd0, ChkErr}, 32'd0);

        // ---- reset mid-stream, then restart ----
        start_load(10'd2);
        foreach (img_q[i]) if (i < 6) send_byte(img_q[i], 0);
        Reset = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ByteReady}, 32'd0);
        chk("midrst_busy",  {31'd0, Busy}, 32'd0);
        chk("midrst_hold",  {31'd0, CpuHold}, 32'd0);
        chk("midrst_data",  WrData, 32'd0);
        chk("midrst_addr",  WrAddress, 32'd0);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        chk("midrst_nwrites", 32'(wa_q.size()), 32'd1);
        @(negedge Clk);
        img_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_q = '{32'hDEADBEEF};
        run_load(10'd1, 25, 8'h22);
        wait_done("restart");
        check_results("restart", 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // ---- checksum error holds until next Start ----
        img_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(10'd1, 0, 8'h05);
        wait_done("chk_hold");
        repeat (5) @(negedge Clk);
        chk("chkerr_held", {31'd0, ChkErr}, 32'd1);
        start_load(10'd1);
        chk("chkerr_cleared", {31'd0, ChkErr}, 32'd0);
        foreach (img_q[i]) send_byte(img_q[i], 0);
        send_byte(8'h04, 0);
        wait_done("chk_clear");
        chk("chkerr_ok", {31'd0, ChkErr}, 32'd0);
`endif

        // ---- clamp: oversized WordCount loads exactly the full memory ----
        img_q.delete();
        for (int i = 0; i < 4 * MAX_WORDS; i++) img_q.push_back(8'($urandom_range(255)));
        model(700, x);
        run_load(10'd700, 0, x);
        wait_done("clamp");
        check_results("clamp", 1'b0);

        // ---- randomized loads against the model ----
        for (int r = 0; r < 15; r++) begin
            int cnt;
            logic [7:0] cb;
            logic e;
            cnt = $urandom_range(1, 6);
            img_q.delete();
            for (int i = 0; i < 4 * cnt; i++) img_q.push_back(8'($urandom_range(255)));
            model(cnt, x);
            cb = $urandom_range(1) ? x : 8'($urandom_range(255));
            e  = (cb != x);
            run_load(10'(cnt), int'($urandom_range(60)), cb);
            wait_done("rand");
            check_results($sformatf("rand%0d", r), e);
            repeat ($urandom_range(3)) @(negedge Clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
